fc_stream_tx: RTL

Output-side transmitter for the fully-connected layer. It buffers the NUM_OUT neuron accumulator results written by the MAC array. On `start`, it streams them one word per cycle on a valid-only 32-bit stream (`data_out`/`valid_out`), which feeds the ReLU stage directly. It has no back-pressure: downstream must accept one word per cycle while `valid_out` is high.

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_stream_tx_if.sv | 42 ++++
 rtl/fc_sat_add.sv | 31 +++
 rtl/fc_stream_tx.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the FC output transmitter.
// Saturation limits are used when FC_BIAS_ADD_EN is defined.
package fc_pkg;

  localparam int FC_DATA_W  = 32;
  localparam int FC_NUM_OUT = 10;

  localparam logic [FC_DATA_W-1:0] FC_SAT_MAX =
    {1'b0, {(FC_DATA_W-1){1'b1}}};
  localparam logic [FC_DATA_W-1:0] FC_SAT_MIN =
    {1'b1, {(FC_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fc_tx_state_t;

endpackage

// File: rtl/fc_stream_tx_if.sv
// Write port and output stream of fc_stream_tx.
// FC_BIAS_ADD_EN adds the bias_wr_en strobe.
interface fc_stream_tx_if
  import fc_pkg::*;
#(
  parameter int DATA_W  = FC_DATA_W,
  parameter int NUM_OUT = FC_NUM_OUT
);
  localparam int AW = $clog2(NUM_OUT);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
`ifdef FC_BIAS_ADD_EN
  logic              bias_wr_en;
`endif
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              last_out;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start,
`ifdef FC_BIAS_ADD_EN
    output bias_wr_en,
`endif
    input  busy, data_out, valid_out,
    input  last_out, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start,
`ifdef FC_BIAS_ADD_EN
    input  bias_wr_en,
`endif
    output busy, data_out, valid_out,
    output last_out, done
  );

endinterface

// File: rtl/fc_sat_add.sv
// Combinational signed saturating adder for bias addition.
// Compiled only when FC_BIAS_ADD_EN is defined.
`ifdef FC_BIAS_ADD_EN
module fc_sat_add
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);
  localparam logic [DATA_W-1:0] W_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] W_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] w_sum;

  assign w_sum = {i_a[DATA_W-1], i_a}
               + {i_b[DATA_W-1], i_b};

  // Top two bits disagree only on signed overflow.
  always_comb begin
    o_sum = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1])
      o_sum = w_sum[DATA_W] ? W_MIN : W_MAX;
  end

endmodule
`endif

// File: rtl/fc_stream_tx.sv
// Buffers NUM_OUT accumulator words and streams them per start.
// FC_BIAS_ADD_EN adds a bias buffer and a saturating add.
module fc_stream_tx
  import fc_pkg::*;
#(
  parameter int DATA_W  = FC_DATA_W,
  parameter int NUM_OUT = FC_NUM_OUT
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_stream_tx_if.slave bus
);
  localparam int AW = $clog2(NUM_OUT);
  localparam logic [AW-1:0] LAST_IDX =
    AW'(NUM_OUT - 1);
  localparam logic [AW:0] LIMIT =
    (AW+1)'(NUM_OUT);

  fc_tx_state_t r_state, w_state_nxt;

  logic [AW-1:0]     r_idx, w_idx_nxt, w_rd_idx;
  logic              w_emit, w_fin, w_wr_ok;
  logic [DATA_W-1:0] w_word;

  logic [DATA_W-1:0] r_buf [NUM_OUT];
  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_busy;
  logic              r_last, r_done;

  // r_idx is the index currently on the output.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rd_idx    = '0;
    w_emit      = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = STREAM;
          w_idx_nxt   = '0;
          w_emit      = 1'b1;
        end
      end
      STREAM: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DONE;
          w_fin       = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
          w_rd_idx  = r_idx + 1'b1;
          w_emit    = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign w_wr_ok = (r_state == IDLE) && !bus.start
                && ({1'b0, bus.wr_addr} < LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++)
        r_buf[i] <= '0;
    end else if (bus.wr_en && w_wr_ok) begin
      r_buf[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef FC_BIAS_ADD_EN
  logic [DATA_W-1:0] r_bias [NUM_OUT];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++)
        r_bias[i] <= '0;
    end else if (bus.bias_wr_en && w_wr_ok) begin
      r_bias[bus.wr_addr] <= bus.wr_data;
    end
  end

  fc_sat_add #(.DATA_W(DATA_W)) u_sat (
    .i_a   (r_buf[w_rd_idx]),
    .i_b   (r_bias[w_rd_idx]),
    .o_sum (w_word)
  );
`else
  assign w_word = r_buf[w_rd_idx];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_emit;
      r_busy  <= w_emit;
      r_last  <= w_emit && (w_rd_idx == LAST_IDX);
      r_done  <= w_fin;
      if (w_emit)
        r_data <= w_word;
    end
  end

  assign bus.data_out  = r_data;
  assign bus.valid_out = r_valid;
  assign bus.busy      = r_busy;
  assign bus.last_out  = r_last;
  assign bus.done      = r_done;

endmodule
